// File: rtl/sdram_pattern_tester.sv
// Self-test engine for sdram_cntr: writes every page in [PAGE_FIRST, PAGE_LAST] with each
// enabled pattern, reads the pages back, and reports pass/fail, error count and first failure.
module sdram_pattern_tester #(
  parameter int ROW_W  = 13,
  parameter int COL_W  = 9,
  parameter int BANK_W = 2,
  parameter int DATA_W = 16,
  parameter logic [BANK_W+ROW_W-1:0] PAGE_FIRST = '0,
  parameter logic [BANK_W+ROW_W-1:0] PAGE_LAST  = '1,
  parameter logic [3:0] PAT_MASK = 4'hF,
  parameter int ERR_W   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_start,
  input  logic                            i_ready,
  output logic [BANK_W+ROW_W+COL_W-1:0]   o_ram_addr,
  output logic [COL_W:0]                  o_ram_len,
  output logic                            o_ram_write_req,
  input  logic                            i_ram_write_valid,
  output logic [DATA_W-1:0]               o_ram_wdata,
  output logic                            o_ram_read_req,
  input  logic                            i_ram_read_valid,
  input  logic [DATA_W-1:0]               i_ram_rdata,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_pass,
  output logic                            o_timeout,
  output logic [ERR_W-1:0]                o_err_count,
  output logic [BANK_W+ROW_W+COL_W-1:0]   o_first_err_addr,
  output logic [DATA_W-1:0]               o_first_err_exp,
  output logic [DATA_W-1:0]               o_first_err_got
);
  localparam int PAGE_W    = BANK_W + ROW_W;
  localparam int AW        = PAGE_W + COL_W;
  localparam int PAGE_SIZE = 1 << COL_W;
  localparam int WD_W      = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, WAIT_RDY, WR_REQ, WR_DATA, WR_NEXT, RD_REQ, RD_DATA, RD_NEXT, PAT_NEXT, DONE
  } state_t;

  state_t            state;
  logic [PAGE_W-1:0] page;
  logic [COL_W:0]    col;
  logic [1:0]        pat;
  logic [WD_W-1:0]   wd;
  logic              err_seen;

  logic [AW-1:0]     word_addr;
  logic [DATA_W-1:0] alt_word, addr_word, exp_word;
  logic [1:0]        first_pat, nxt_pat;
  logic              nxt_ok, last_col, wd_hit;

  assign word_addr   = {page, col[COL_W-1:0]};
  assign o_ram_addr  = {page, {COL_W{1'b0}}};
  assign o_ram_len   = {1'b1, {COL_W{1'b0}}};
  assign o_ram_wdata = exp_word;
  assign last_col    = (col == (COL_W+1)'(PAGE_SIZE - 1));
  assign wd_hit      = (wd == WD_W'(TIMEOUT - 1));

  // Address pattern: low DATA_W bits of the word address, zero-extended when narrower.
  if (DATA_W <= AW) begin : g_addr_trunc
    assign addr_word = word_addr[DATA_W-1:0];
  end else begin : g_addr_ext
    assign addr_word = {{(DATA_W-AW){1'b0}}, word_addr};
  end

  always_comb begin
    alt_word = '0;
    for (int b = 0; b < DATA_W; b++) alt_word[b] = b[0] ^ col[0];
    case (pat)
      2'd0:    exp_word = '0;
      2'd1:    exp_word = '1;
      2'd2:    exp_word = alt_word;
      default: exp_word = addr_word;
    endcase
  end

  // Lowest enabled pattern, and the next enabled pattern above the current one.
  always_comb begin
    first_pat = '0;
    nxt_pat   = '0;
    nxt_ok    = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (PAT_MASK[k]) first_pat = 2'(k);
      if (PAT_MASK[k] && k > int'(pat)) begin
        nxt_pat = 2'(k);
        nxt_ok  = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= IDLE;
      page             <= '0;
      col              <= '0;
      pat              <= '0;
      wd               <= '0;
      err_seen         <= 1'b0;
      o_ram_write_req  <= 1'b0;
      o_ram_read_req   <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_pass           <= 1'b0;
      o_timeout        <= 1'b0;
      o_err_count      <= '0;
      o_first_err_addr <= '0;
      o_first_err_exp  <= '0;
      o_first_err_got  <= '0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          o_busy           <= 1'b1;
          o_done           <= 1'b0;
          o_pass           <= 1'b0;
          o_timeout        <= 1'b0;
          o_err_count      <= '0;
          err_seen         <= 1'b0;
          o_first_err_addr <= '0;
          o_first_err_exp  <= '0;
          o_first_err_got  <= '0;
          pat              <= first_pat;
          page             <= PAGE_FIRST;
          col              <= '0;
          state            <= (PAT_MASK == 4'b0) ? DONE : WAIT_RDY;
        end
        WAIT_RDY: if (i_ready) state <= WR_REQ;
        WR_REQ: begin
          o_ram_write_req <= 1'b1;
          col             <= '0;
          wd              <= '0;
          state           <= WR_DATA;
        end
        WR_DATA: begin
          if (i_ram_write_valid) begin
            o_ram_write_req <= 1'b0;
            col             <= col + (COL_W+1)'(1);
            wd              <= '0;
            if (last_col) state <= WR_NEXT;
          end else if (wd_hit) begin
            o_timeout       <= 1'b1;
            o_ram_write_req <= 1'b0;
            state           <= DONE;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        WR_NEXT: begin
          if (page == PAGE_LAST) begin
            page  <= PAGE_FIRST;
            state <= RD_REQ;
          end else begin
            page  <= page + PAGE_W'(1);
            state <= WR_REQ;
          end
        end
        RD_REQ: begin
          o_ram_read_req <= 1'b1;
          col            <= '0;
          wd             <= '0;
          state          <= RD_DATA;
        end
        RD_DATA: begin
          if (i_ram_read_valid) begin
            o_ram_read_req <= 1'b0;
            col            <= col + (COL_W+1)'(1);
            wd             <= '0;
            if (last_col) state <= RD_NEXT;
            if (i_ram_rdata != exp_word) begin
              if (o_err_count != '1) o_err_count <= o_err_count + ERR_W'(1);
              // Only the first mismatch of a run is recorded.
              if (!err_seen) begin
                err_seen         <= 1'b1;
                o_first_err_addr <= word_addr;
                o_first_err_exp  <= exp_word;
                o_first_err_got  <= i_ram_rdata;
              end
            end
          end else if (wd_hit) begin
            o_timeout      <= 1'b1;
            o_ram_read_req <= 1'b0;
            state          <= DONE;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        RD_NEXT: begin
          if (page != PAGE_LAST) begin
            page  <= page + PAGE_W'(1);
            state <= RD_REQ;
          end else begin
            state <= PAT_NEXT;
          end
        end
        PAT_NEXT: begin
          if (nxt_ok) begin
            pat   <= nxt_pat;
            page  <= PAGE_FIRST;
            state <= WR_REQ;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          o_busy <= 1'b0;
          o_done <= 1'b1;
          o_pass <= (o_err_count == '0) && !o_timeout;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Bench: three tester instances (full range, narrow range/pattern 3, short timeout/4-bit errors)
// driven by a controller BFM; a transaction-list model predicts every transfer and the result.
module tb_sdram_pattern_tester;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[3], start[3], ready[3], wv[3], rv[3];
  logic [15:0] rdata[3];
  wire  [5:0]  addr[3], fea[3];
  wire  [3:0]  len[3];
  wire         wreq[3], rreq[3], busy[3], done[3], pass[3], tmo[3];
  wire  [15:0] wdata[3], errc[3], fexp[3], fgot[3];
  wire  [3:0]  errc_c;
  assign errc[2] = {12'b0, errc_c};

  sdram_pattern_tester #(.ROW_W(2), .COL_W(3), .BANK_W(1), .DATA_W(16), .TIMEOUT(64)) dut_a (
    .i_clk(clk), .i_rst(rst[0]), .i_start(start[0]), .i_ready(ready[0]),
    .o_ram_addr(addr[0]), .o_ram_len(len[0]), .o_ram_write_req(wreq[0]),
    .i_ram_write_valid(wv[0]), .o_ram_wdata(wdata[0]), .o_ram_read_req(rreq[0]),
    .i_ram_read_valid(rv[0]), .i_ram_rdata(rdata[0]), .o_busy(busy[0]), .o_done(done[0]),
    .o_pass(pass[0]), .o_timeout(tmo[0]), .o_err_count(errc[0]), .o_first_err_addr(fea[0]),
    .o_first_err_exp(fexp[0]), .o_first_err_got(fgot[0]));

  sdram_pattern_tester #(.ROW_W(2), .COL_W(3), .BANK_W(1), .DATA_W(16), .TIMEOUT(64),
    .PAGE_FIRST(3'd2), .PAGE_LAST(3'd3), .PAT_MASK(4'b1000)) dut_b (
    .i_clk(clk), .i_rst(rst[1]), .i_start(start[1]), .i_ready(ready[1]),
    .o_ram_addr(addr[1]), .o_ram_len(len[1]), .o_ram_write_req(wreq[1]),
    .i_ram_write_valid(wv[1]), .o_ram_wdata(wdata[1]), .o_ram_read_req(rreq[1]),
    .i_ram_read_valid(rv[1]), .i_ram_rdata(rdata[1]), .o_busy(busy[1]), .o_done(done[1]),
    .o_pass(pass[1]), .o_timeout(tmo[1]), .o_err_count(errc[1]), .o_first_err_addr(fea[1]),
    .o_first_err_exp(fexp[1]), .o_first_err_got(fgot[1]));

  sdram_pattern_tester #(.ROW_W(2), .COL_W(3), .BANK_W(1), .DATA_W(16), .TIMEOUT(16),
    .ERR_W(4)) dut_c (
    .i_clk(clk), .i_rst(rst[2]), .i_start(start[2]), .i_ready(ready[2]),
    .o_ram_addr(addr[2]), .o_ram_len(len[2]), .o_ram_write_req(wreq[2]),
    .i_ram_write_valid(wv[2]), .o_ram_wdata(wdata[2]), .o_ram_read_req(rreq[2]),
    .i_ram_read_valid(rv[2]), .i_ram_rdata(rdata[2]), .o_busy(busy[2]), .o_done(done[2]),
    .o_pass(pass[2]), .o_timeout(tmo[2]), .o_err_count(errc_c), .o_first_err_addr(fea[2]),
    .o_first_err_exp(fexp[2]), .o_first_err_got(fgot[2]));

  int total = 0, bad = 0;
  int pfirst[3] = '{0, 2, 0};
  int plast[3]  = '{7, 3, 7};
  int pmask[3]  = '{15, 8, 15};
  int errmax[3] = '{65535, 65535, 15};

  // Expected transfer list per instance: {dir(1=write), pattern[1:0], addr[5:0]}.
  int          q[3][$];
  bit          stall[3], noread[3], bdir[3], m_seen[3];
  int          cmode[3], rem[3], idx[3], base[3], popcnt[3], mina[3], maxa[3], reqhi[3];
  int          m_err[3], m_fa[3], m_fe[3], m_fg[3];
  logic [15:0] mem[3][64];

  task automatic chk(input string n, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pat_of(input int k, input int a);
    case (k)
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return (a % 2 == 1) ? 16'h5555 : 16'hAAAA;
      default: return 16'(a);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Controller BFM plus per-transfer comparison against the expected list.
  task automatic bfm_step(input int i);
    int e, a, k;
    logic [15:0] d;
    bit go;
    wv[i] = 1'b0;
    rv[i] = 1'b0;
    if (rst[i]) begin
      rem[i] = 0;
      return;
    end
    if (rreq[i]) reqhi[i]++;
    if (rem[i] == 0 && (wreq[i] || rreq[i])) begin
      chk("req_exclusive", wreq[i] && rreq[i], 0);
      chk("burst_len", len[i], 8);
      bdir[i] = wreq[i];
      base[i] = addr[i];
      rem[i]  = 8;
      idx[i]  = 0;
    end
    if (rem[i] == 0) return;
    go = !(stall[i] && $urandom_range(0, 3) == 0) && !(noread[i] && !bdir[i]);
    if (!go) return;
    chk("xfer_expected", q[i].size() > 0, 1);
    if (q[i].size() == 0) begin
      rem[i] = 0;
      return;
    end
    e = q[i].pop_front();
    k = (e >> 6) & 3;
    a = base[i] + idx[i];
    chk("xfer_dir", bdir[i], (e >> 8) & 1);
    chk("xfer_addr", a, e & 63);
    popcnt[i]++;
    if (a < mina[i]) mina[i] = a;
    if (a > maxa[i]) maxa[i] = a;
    if (bdir[i]) begin
      wv[i] = 1'b1;
      chk("wdata", wdata[i], pat_of(k, e & 63));
      mem[i][a[5:0]] = wdata[i];
    end else begin
      rv[i] = 1'b1;
      d = mem[i][a[5:0]];
      case (cmode[i])
        1: if (k == 2 && a == 42) d = d ^ 16'h0001;
        2: d = d ^ 16'h8000;
        3: if ($urandom_range(0, 15) == 0) d = d ^ (16'h1 << $urandom_range(0, 15));
        default: ;
      endcase
      rdata[i] = d;
      if (d != pat_of(k, e & 63)) begin
        if (m_err[i] < errmax[i]) m_err[i]++;
        if (!m_seen[i]) begin
          m_seen[i] = 1'b1;
          m_fa[i] = e & 63;
          m_fe[i] = pat_of(k, e & 63);
          m_fg[i] = d;
        end
      end
    end
    idx[i]++;
    rem[i]--;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      wv[i] = 1'b0; rv[i] = 1'b0; rdata[i] = '0; rem[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) bfm_step(i);
    end
  end

  task automatic build_q(input int i);
    q[i].delete();
    for (int k = 0; k < 4; k++)
      if (((pmask[i] >> k) & 1) == 1)
        for (int w = 1; w >= 0; w--)
          for (int p = pfirst[i]; p <= plast[i]; p++)
            for (int c = 0; c < 8; c++) q[i].push_back((w << 8) | (k << 6) | (p * 8 + c));
    m_err[i] = 0; m_seen[i] = 1'b0; m_fa[i] = 0; m_fe[i] = 0; m_fg[i] = 0;
    popcnt[i] = 0; mina[i] = 999; maxa[i] = -1; reqhi[i] = 0;
  endtask

  task automatic run(input int i, input bit do_rst, input bit exp_to, input int exp_left,
                     input bit rnd);
    int cyc;
    if (do_rst) begin
      rst[i] = 1'b1; tick(); tick(); rst[i] = 1'b0; tick();
      chk("rst_busy", busy[i], 0);       chk("rst_done", done[i], 0);
      chk("rst_pass", pass[i], 0);       chk("rst_timeout", tmo[i], 0);
      chk("rst_err", errc[i], 0);        chk("rst_wreq", wreq[i], 0);
      chk("rst_rreq", rreq[i], 0);       chk("rst_addr", addr[i], 0);
      chk("rst_wdata", wdata[i], 0);     chk("rst_fea", fea[i], 0);
      chk("rst_fexp", fexp[i], 0);       chk("rst_fgot", fgot[i], 0);
    end
    build_q(i);
    ready[i] = !rnd;
    start[i] = 1'b1; tick(); start[i] = 1'b0;
    if (rnd) begin
      repeat (6) tick();
      chk("hold_until_ready", wreq[i] || rreq[i], 0);
      chk("busy_wait_ready", busy[i], 1);
      ready[i] = 1'b1;
    end
    cyc = 0;
    while (!done[i] && cyc < 5000) begin
      tick();
      cyc++;
      start[i] = rnd && (cyc == 100);
      if (rnd && cyc == 60) ready[i] = 1'b0;
    end
    start[i] = 1'b0;
    ready[i] = 1'b1;
    chk("run_finished", done[i], 1);
    chk("end_busy", busy[i], 0);
    chk("end_timeout", tmo[i], exp_to);
    chk("end_err", errc[i], m_err[i]);
    chk("end_pass", pass[i], (m_err[i] == 0) && !exp_to);
    chk("end_fea", fea[i], m_fa[i]);
    chk("end_fexp", fexp[i], m_fe[i]);
    chk("end_fgot", fgot[i], m_fg[i]);
    chk("end_left", q[i].size(), exp_left);
    chk("end_reqs", wreq[i] || rreq[i], 0);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; ready[i] = 1'b1;
      stall[i] = 1'b0; noread[i] = 1'b0; cmode[i] = 0;
    end
    repeat (3) tick();
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    // Ideal controller, all four patterns over pages 0..7.
    run(0, 1, 0, 0, 0);
    chk("t1_words", popcnt[0], 512);
    chk("t1_pass", pass[0], 1);
    chk("t1_err", errc[0], 0);

    // Single flipped bit at page 5 col 2 in the alternating pattern.
    cmode[0] = 1;
    run(0, 1, 0, 0, 0);
    chk("t2_err", errc[0], 1);
    chk("t2_addr", fea[0], 6'h2A);
    chk("t2_exp", fexp[0], 16'hAAAA);
    chk("t2_got", fgot[0], 16'hAAAB);
    chk("t2_pass", pass[0], 0);
    cmode[0] = 0;

    // Address pattern only, pages 2..3.
    run(1, 1, 0, 0, 0);
    chk("t3_words", popcnt[1], 32);
    chk("t3_min_addr", mina[1], 6'h10);
    chk("t3_max_addr", maxa[1], 6'h1F);
    chk("t3_pass", pass[1], 1);

    // Reads never answered: stall abort.
    noread[2] = 1'b1;
    run(2, 1, 1, 448, 0);
    chk("t4_timeout", tmo[2], 1);
    chk("t4_pass", pass[2], 0);
    chk("t4_words", popcnt[2], 64);
    chk("t4_req_window", reqhi[2] >= 1 && reqhi[2] <= 17, 1);
    noread[2] = 1'b0;

    // Every read corrupted: 4-bit counter saturates.
    cmode[2] = 2;
    run(2, 1, 0, 0, 0);
    chk("t5_err_sat", errc[2], 15);
    chk("t5_pass", pass[2], 0);
    cmode[2] = 0;

    // Reset in the middle of a write burst, then a clean run without further reset.
    rst[0] = 1'b1; tick(); tick(); rst[0] = 1'b0; tick();
    build_q(0);
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    cyc = 0;
    while (popcnt[0] < 4 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("t6_mid_col", popcnt[0], 4);
    rst[0] = 1'b1; tick();
    chk("t6_wreq", wreq[0], 0);
    chk("t6_busy", busy[0], 0);
    rst[0] = 1'b0; tick();
    run(0, 0, 0, 0, 0);
    chk("t6_clean_pass", pass[0], 1);

    // Randomized gaps and corruption, ready drop and start pulse mid-run.
    for (int r = 0; r < 3; r++) begin
      stall[0] = 1'b1; cmode[0] = 3;
      run(0, 1, 0, 0, 1);
    end
    stall[2] = 1'b1; cmode[2] = 3;
    run(2, 1, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
